// File: rtl/range_stream_gen_if.sv
// range_stream_gen_if -- bus between the self-test stream generator and its user.
//   start/seed/step/length : burst request (driven by master)
//   range_in               : range finder result to compare against
//   data_out/go/finish     : framed stream toward the range finder
//   busy/done              : transaction status
//   expected_range         : reference max - min of the last burst
//   mismatch/cfg_err       : sticky compare failure, zero-length request pulse
interface range_stream_gen_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
);
  logic             start;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] step;
  logic [LEN_W-1:0] length;
  logic [WIDTH-1:0] range_in;
  logic [WIDTH-1:0] data_out;
  logic             go;
  logic             finish;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] expected_range;
  logic             mismatch;
  logic             cfg_err;

  modport master (
    output start, seed, step, length, range_in,
    input  data_out, go, finish, busy, done, expected_range, mismatch, cfg_err
  );

  modport slave (
    input  start, seed, step, length, range_in,
    output data_out, go, finish, busy, done, expected_range, mismatch, cfg_err
  );
endinterface

// File: rtl/range_stream_gen.sv
// range_stream_gen -- emits an LCG burst (word' = word*5 + step) framed by
// go/finish, tracks max - min of the burst and reports it at done.
// Optional macro RANGE_GEN_CHECK_EN: compare bus.range_in against the
// computed range in the CHECK cycle and raise a sticky mismatch flag.
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous, active high
//   bus   : range_stream_gen_if slave modport (request, stream, status)
module range_stream_gen #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  range_stream_gen_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, CHECK} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] data_q, step_q, min_q, max_q, range_q;
  logic [LEN_W-1:0] left_q;   // words still to emit after the one on data_q
  logic             go_q, fin_q, busy_q, done_q, cfg_err_q;

  logic [WIDTH-1:0] word_d, min_d, max_d;

  // word*5 as shift+add keeps everything WIDTH bits, so wrap is implicit
  assign word_d = (data_q << 2) + data_q + step_q;
  assign min_d  = (word_d < min_q) ? word_d : min_q;
  assign max_d  = (word_d > max_q) ? word_d : max_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      data_q    <= '0;
      step_q    <= '0;
      min_q     <= '1;
      max_q     <= '0;
      range_q   <= '0;
      left_q    <= '0;
      go_q      <= 1'b0;
      fin_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      go_q      <= 1'b0;
      fin_q     <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.length == '0) begin
              cfg_err_q <= 1'b1;
            end else begin
              state_q <= RUN;
              data_q  <= bus.seed;
              step_q  <= bus.step;
              left_q  <= bus.length - LEN_W'(1);
              go_q    <= 1'b1;
              fin_q   <= (bus.length == LEN_W'(1));
              busy_q  <= 1'b1;
              // min/max restart at all-ones/zero and fold word0 in at once
              min_q   <= bus.seed;
              max_q   <= bus.seed;
            end
          end
        end
        RUN: begin
          if (fin_q) begin
            state_q <= CHECK;
            done_q  <= 1'b1;
            range_q <= max_q - min_q;  // max >= min, never wraps
          end else begin
            data_q <= word_d;
            left_q <= left_q - LEN_W'(1);
            fin_q  <= (left_q == LEN_W'(1));
            min_q  <= min_d;
            max_q  <= max_d;
          end
        end
        CHECK: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef RANGE_GEN_CHECK_EN
  logic mismatch_q;

  // range_q holds the fresh max - min during CHECK; that is the cycle the
  // range finder's own answer is valid on range_in.
  always_ff @(posedge clock) begin
    if (reset) begin
      mismatch_q <= 1'b0;
    end else if (state_q == IDLE && bus.start && bus.length != '0) begin
      mismatch_q <= 1'b0;
    end else if (state_q == CHECK && bus.range_in != range_q) begin
      mismatch_q <= 1'b1;
    end
  end

  assign bus.mismatch = mismatch_q;
`else
  logic unused_range_in;
  assign unused_range_in = ^bus.range_in;
  assign bus.mismatch    = 1'b0;
`endif

  assign bus.data_out       = data_q;
  assign bus.go             = go_q;
  assign bus.finish         = fin_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.expected_range = range_q;
  assign bus.cfg_err        = cfg_err_q;

endmodule

// File: tb/tb_range_stream_gen.sv
module tb_range_stream_gen;
  localparam int WIDTH = 8;
  localparam int LEN_W = 8;

  logic clk, rst;
  range_stream_gen_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

  range_stream_gen #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] w;
    logic       g;
    logic       f;
  } exp_t;

  exp_t       wq[$];
  logic [7:0] rq[$];
  logic       in_b;
  int         total, bad;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // driver acts 1 time unit after the falling edge; monitor samples on it
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // scoreboard side: pop one expected word per streamed cycle, one range per done
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.go) in_b = 1'b1;
      if (in_b) begin
        if (wq.size() == 0) begin
          chk("wq_nonempty", 32'(wq.size() != 0), 1);
        end else begin
          exp_t e;
          e = wq.pop_front();
          chk("word", bus.data_out, e.w);
          chk("go", bus.go, e.g);
          chk("finish", bus.finish, e.f);
        end
        if (bus.finish) in_b = 1'b0;
      end
      if (bus.done) begin
        if (rq.size() == 0) chk("rq_nonempty", 32'(rq.size() != 0), 1);
        else chk("range", bus.expected_range, rq.pop_front());
      end
    end
  end

  function automatic logic [7:0] lcg(input logic [7:0] w, input logic [7:0] st);
    logic [7:0] r;
    r = w * 8'd5 + st;
    return r;
  endfunction

  task automatic run(input logic [7:0] sd, input logic [7:0] st, input logic [7:0] len,
                     input logic [7:0] rin, input int poke);
    logic [7:0] w, mn, mx;
    logic       exp_mis;
    int         n;
    w = sd; mn = 8'hFF; mx = 8'h00;
    for (int i = 0; i < int'(len); i++) begin
      wq.push_back('{w: w, g: (i == 0), f: (i == int'(len) - 1)});
      if (w < mn) mn = w;
      if (w > mx) mx = w;
      w = lcg(w, st);
    end
    rq.push_back(mx - mn);
`ifdef RANGE_GEN_CHECK_EN
    exp_mis = (rin != (mx - mn));
`else
    exp_mis = 1'b0;
`endif
    bus.seed = sd; bus.step = st; bus.length = len; bus.start = 1'b1;
    tick();                       // cycle T+1
    bus.start = 1'b0; bus.range_in = rin;
    n = 1;
    chk("mis_clr", bus.mismatch, 0);
    chk("busy_run", bus.busy, 1);
    while (!bus.done && n < 400) begin
      tick();
      n++;
      if (n == poke) begin
        bus.start = 1'b1; bus.seed = 8'h55; bus.step = 8'h77; bus.length = 8'd9;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    chk("done_lat", n, 32'(len) + 1);
    chk("busy_chk", bus.busy, 1);
    tick();                       // back in IDLE
    chk("mismatch", bus.mismatch, exp_mis);
    chk("busy_end", bus.busy, 0);
    chk("done_end", bus.done, 0);
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_data"}, bus.data_out, 0);
    chk({tag, "_go"}, bus.go, 0);
    chk({tag, "_fin"}, bus.finish, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_rng"}, bus.expected_range, 0);
    chk({tag, "_mis"}, bus.mismatch, 0);
    chk({tag, "_cfg"}, bus.cfg_err, 0);
  endtask

  initial begin
    logic seen;
    total = 0; bad = 0; in_b = 1'b0;
    rst = 1'b1;
    bus.start = 1'b0; bus.seed = '0; bus.step = '0; bus.length = '0; bus.range_in = '0;
    tick(); tick();
    outs_zero("rst");
    rst = 1'b0;
    tick();

    run(8'h10, 8'h03, 8'd4, 8'h92, 0);
    run(8'h10, 8'h03, 8'd4, 8'h91, 0);
    tick(); tick();
`ifdef RANGE_GEN_CHECK_EN
    chk("mis_hold", bus.mismatch, 1);
`else
    chk("mis_hold", bus.mismatch, 0);
`endif
    run(8'hFF, 8'h01, 8'd2, 8'h03, 0);
    run(8'h7F, 8'h00, 8'd1, 8'h00, 0);

    // zero-length request
    bus.length = 8'd0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("cfg_err", bus.cfg_err, 1);
    chk("cfg_busy", bus.busy, 0);
    chk("cfg_go", bus.go, 0);
    tick();
    chk("cfg_err_pulse", bus.cfg_err, 0);
    chk("cfg_done", bus.done, 0);

    // start reasserted mid-burst with different settings is ignored
    run(8'h10, 8'h03, 8'd4, 8'h92, 2);

    // reset at T+2 abandons the burst
    begin
      logic [7:0] w;
      w = 8'h10;
      for (int i = 0; i < 4; i++) begin
        wq.push_back('{w: w, g: (i == 0), f: (i == 3)});
        w = lcg(w, 8'h03);
      end
      rq.push_back(8'h92);
    end
    bus.seed = 8'h10; bus.step = 8'h03; bus.length = 8'd4; bus.start = 1'b1;
    tick();                       // T+1
    bus.start = 1'b0;
    tick();                       // T+2
    rst = 1'b1;
    tick();                       // T+3
    outs_zero("mid_rst");
    wq.delete(); rq.delete(); in_b = 1'b0;
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (bus.finish || bus.go || bus.done) seen = 1'b1;
    end
    chk("no_finish", seen, 0);

    run(8'h33, 8'h07, 8'd5, 8'h00, 0);
    run(8'hA5, 8'h3B, 8'd20, 8'hFE, 0);

    chk("wq_left", wq.size(), 0);
    chk("rq_left", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
